// File: rtl/spu_ls_pkg.sv
// spu_ls_pkg: shared DMA state encoding and direction constants for the local store
package spu_ls_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ST_FETCH = 3'd2,
        S_ST_SEND  = 3'd3,
        S_DONE     = 3'd4
    } dma_state_t;

    localparam logic DMA_DIR_LOAD  = 1'b0;
    localparam logic DMA_DIR_STORE = 1'b1;

endpackage

// File: rtl/spu_ls_ram.sv
// spu_ls_ram: single-port word array, asynchronous read and synchronous write
module spu_ls_ram #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [2**ADDRBITS];

    assign rdata = mem[addr];

    // write the selected word at the clock edge; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/spu_local_store.sv
// spu_local_store: core-priority local store with a one-channel block DMA engine
module spu_local_store #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 10,
    parameter int LENBITS  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memread,
    input  logic                memwrite,
    input  logic [WIDTH-1:0]    adr,
    input  logic [WIDTH-1:0]    writedata,
    output logic [WIDTH-1:0]    memdata,
    input  logic                dma_start,
    input  logic                dma_dir,
    input  logic [ADDRBITS-1:0] dma_lsa,
    input  logic [LENBITS-1:0]  dma_len,
    output logic                dma_busy,
    output logic                dma_done,
    input  logic [WIDTH-1:0]    ext_rdata,
    input  logic                ext_rvalid,
    output logic                ext_rready,
    output logic [WIDTH-1:0]    ext_wdata,
    output logic                ext_wvalid,
    input  logic                ext_wready
);

    import spu_ls_pkg::*;

    dma_state_t          state, state_d;
    logic [ADDRBITS-1:0] ptr, ptr_d;
    logic [LENBITS-1:0]  cnt, cnt_d;
    logic [WIDTH-1:0]    wdata_d, rdata;
    logic                spu_act, ld_we, adr_unused;

    assign adr_unused = ^adr[WIDTH-1:ADDRBITS];
    assign spu_act    = memread | memwrite;
    assign ext_rready = (state == S_LOAD) & ~spu_act & ~reset;
    assign ld_we      = ext_rready & ext_rvalid;
    assign ext_wvalid = state == S_ST_SEND;
    assign dma_busy   = state != S_IDLE;
    assign dma_done   = state == S_DONE;
    assign memdata    = rdata;

    spu_ls_ram #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS)) u_ram (
        .clk   (clk),
        .we    (memwrite | ld_we),
        .addr  (spu_act ? adr[ADDRBITS-1:0] : ptr),
        .wdata (spu_act ? writedata : ext_rdata),
        .rdata (rdata)
    );

    // DMA sequencing: the core owns the port whenever it strobes, DMA steps only in idle cycles
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        wdata_d = ext_wdata;
        case (state)
            S_IDLE: if (dma_start) begin
                ptr_d   = dma_lsa;
                cnt_d   = dma_len;
                state_d = dma_len == '0 ? S_DONE : dma_dir == DMA_DIR_STORE ? S_ST_FETCH : S_LOAD;
            end
            S_LOAD: if (ld_we) begin
                ptr_d   = ptr + 1'b1;
                cnt_d   = cnt - 1'b1;
                state_d = cnt == LENBITS'(1) ? S_DONE : S_LOAD;
            end
            S_ST_FETCH: if (!spu_act) begin
                wdata_d = rdata;
                state_d = S_ST_SEND;
            end
            S_ST_SEND: if (ext_wready) begin
                ptr_d   = ptr + 1'b1;
                cnt_d   = cnt - 1'b1;
                state_d = cnt == LENBITS'(1) ? S_DONE : S_ST_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // DMA state, pointer, count and outbound data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            ext_wdata <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            ext_wdata <= wdata_d;
        end
    end

endmodule

// File: doc/spu_local_store.md
Name: spu_local_store

Overview:
- Word-addressed single-port local store sitting directly downstream of the cellspu core.
- Consumes the core's memread/memwrite/adr/writedata and produces its memdata.
- Embeds a one-channel DMA engine that moves blocks between the store and an external stream interface. DMA only uses the port in cycles the core leaves idle.
- The core has no stall input, so the core always has priority on the port.

Parameters:
- WIDTH, 32, data word width (matches core WIDTH).
- ADDRBITS, 10, local store depth = 2^ADDRBITS words; core adr[ADDRBITS-1:0] selects the word.
- LENBITS, 8, width of the DMA transfer length in words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- memread  in  1  core read strobe
- memwrite  in  1  core write strobe
- adr  in  WIDTH  core word address; upper bits ignored
- writedata  in  WIDTH  core write data
- memdata  out  WIDTH  read data to core
- dma_start  in  1  one-cycle command strobe
- dma_dir  in  1  0 = LOAD (ext->LS), 1 = STORE (LS->ext)
- dma_lsa  in  ADDRBITS  local store start word address
- dma_len  in  LENBITS  transfer length in words
- dma_busy  out  1  transfer in progress
- dma_done  out  1  one-cycle completion pulse
- ext_rdata  in  WIDTH  inbound stream data
- ext_rvalid  in  1  inbound data valid
- ext_rready  out  1  store accepts inbound word
- ext_wdata  out  WIDTH  outbound stream data
- ext_wvalid  out  1  outbound data valid
- ext_wready  in  1  sink accepts outbound word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: dma_busy=0, dma_done=0, ext_rready=0, ext_wvalid=0, ext_wdata=0, FSM=IDLE. Array contents are not cleared.
- Core port:
  - memdata = mem[adr[ADDRBITS-1:0]], combinational, zero-latency read. It is valid whenever memread=1; its value is otherwise don't-care.
  - A core write occurs at the clk edge when memwrite=1.
  - A read in the cycle after a write to the same address returns the new data.
- Port busy: spu_act = memread | memwrite. DMA may touch the array only when spu_act=0.
- FSM states: IDLE, LOAD, ST_FETCH, ST_SEND, DONE.
- IDLE:
  - On dma_start, latch ptr=dma_lsa and cnt=dma_len, and set dma_busy=1.
  - If dma_len=0, go to DONE.
  - Otherwise go to LOAD if dma_dir=0, or ST_FETCH if dma_dir=1.
- LOAD:
  - ext_rready = ~spu_act, combinational.
  - On ext_rvalid & ext_rready: mem[ptr] <= ext_rdata, ptr++, cnt--.
  - Go to DONE when cnt reaches 0.
- ST_FETCH:
  - If ~spu_act, ext_wdata <= mem[ptr] (registered), then go to ST_SEND.
  - If spu_act, stay in ST_FETCH.
- ST_SEND:
  - ext_wvalid=1. ext_wdata is held stable until accepted.
  - On ext_wready: ptr++, cnt--. Go to DONE if cnt becomes 0, else go to ST_FETCH.
  - ext_wvalid must not drop before ext_wready.
- DONE: dma_done=1 for exactly one cycle; dma_busy=0 from the next cycle; return to IDLE.
- dma_start while dma_busy=1 is ignored (no queueing).
- ptr wraps modulo 2^ADDRBITS; cnt is unsigned LENBITS.
- Core and DMA access in the same cycle: the core wins and the DMA access is deferred. No lost or duplicated words; same-address core writes are never clobbered by a deferred DMA write.
- Reset asserted mid-transfer aborts the transfer. No dma_done pulse; words already written stay in the array.
- Core throughput is never affected by DMA.

Decomposition:
- Shared package spu_ls_pkg:
  - FSM state encoding (3 bits).
  - DMA_DIR_LOAD=1'b0, DMA_DIR_STORE=1'b1.
- One sub-module, spu_ls_ram: single-port array with async read, sync write, and a muxed address/data select driven by the parent.

Test Plan:
- Core only: write 0xDEADBEEF at adr 5, then memread adr 5 -> memdata=0xDEADBEEF in the same cycle; adr 0x405 with ADDRBITS=10 aliases to word 5.
- LOAD: lsa=0x3FE, len=4, stream 0x11,0x22,0x33,0x44 with rvalid high -> words 0x3FE,0x3FF,0x000,0x001 hold those values; dma_done pulses once; busy high for 4 cycles plus DONE.
- LOAD contention: memread held high for 3 cycles mid-transfer -> ext_rready low those 3 cycles; all 4 words land correctly; transfer completes 3 cycles late.
- STORE with backpressure: preload words 10..12 with 0xA,0xB,0xC; lsa=10, len=3; ext_wready toggles 0/1 -> ext_wdata sequence A,B,C, each stable while wvalid=1 and wready=0.
- dma_len=0 -> dma_done one cycle after dma_start, no rready/wvalid activity. A second dma_start while busy is ignored.
- Reset at the 2nd of 4 LOAD words -> busy=0 next cycle, no dma_done, word 0 written and word 1+ untouched.
